// File: rtl/img_mem_reader.sv
`default_nettype none
// ============================================================================
//  Module      : img_mem_reader
//  Description : Frame memory serving in-order pixel reads over valid/ready
//                channels, with credit-based output buffering.
//  Revision    : 1.0 - initial release
// ============================================================================
module img_mem_reader #(
    parameter  int W_DATA     = 8,
    parameter  int IMG_WIDTH  = 41,
    parameter  int IMG_HEIGHT = 50,
    parameter  int FIFO_DEPTH = 2,
    localparam int MEM_SIZE   = IMG_WIDTH * IMG_HEIGHT,
    localparam int W_ADDR     = $clog2(MEM_SIZE)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_valid,
    output logic              wr_ready,
    input  logic [W_ADDR-1:0] wr_addr,
    input  logic [W_DATA-1:0] wr_data,
    input  logic              addr_valid,
    output logic              addr_ready,
    input  logic [W_ADDR-1:0] addr,
    output logic              dout_valid,
    input  logic              dout_ready,
    output logic [W_DATA-1:0] dout_data,
    output logic              addr_err
);

    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam int CRD_W = CNT_W + 1;

    localparam logic [W_ADDR:0]    c_MEM_LIMIT = (W_ADDR + 1)'(MEM_SIZE);
    localparam logic [PTR_W-1:0]   c_PTR_LAST  = PTR_W'(FIFO_DEPTH - 1);
    localparam logic [CRD_W-1:0]   c_DEPTH     = CRD_W'(FIFO_DEPTH);

    logic [W_DATA-1:0] r_mem  [0:MEM_SIZE-1];
    logic [W_DATA-1:0] r_fifo [0:FIFO_DEPTH-1];
    logic [W_DATA-1:0] r_s1_data;
    logic              r_s1_v;
    logic [PTR_W-1:0]  r_wr_ptr;
    logic [PTR_W-1:0]  r_rd_ptr;
    logic [CNT_W-1:0]  r_count;
    logic              r_addr_err;

    logic              w_wr_fire;
    logic              w_rd_fire;
    logic              w_wr_oor;
    logic              w_rd_oor;
    logic              w_push;
    logic              w_pop;
    logic [CRD_W-1:0]  w_credits;
    logic [CRD_W-1:0]  w_credits_after;

    function automatic logic [PTR_W-1:0] f_ptr_next(input logic [PTR_W-1:0] p);
        return (p == c_PTR_LAST) ? '0 : p + PTR_W'(1);
    endfunction

    assign wr_ready  = ~rst;
    assign w_wr_fire = wr_valid & wr_ready;
    assign w_rd_fire = addr_valid & addr_ready;
    assign w_wr_oor  = ({1'b0, wr_addr} >= c_MEM_LIMIT);
    assign w_rd_oor  = ({1'b0, addr} >= c_MEM_LIMIT);

    assign dout_valid = (r_count != '0);
    assign dout_data  = dout_valid ? r_fifo[r_rd_ptr] : '0;
    assign addr_err   = r_addr_err;

    assign w_push = r_s1_v;
    assign w_pop  = dout_valid & dout_ready;

    // Credits cover every response already committed (stage + buffer); a slot
    // freed by this cycle's pop may be reused immediately.
    assign w_credits       = CRD_W'(r_s1_v) + CRD_W'(r_count);
    assign w_credits_after = w_credits - CRD_W'(w_pop);
    assign addr_ready      = ~rst & (w_credits_after < c_DEPTH);

    // Nonblocking read of the old word gives read-first behaviour on collisions.
    always_ff @(posedge clk) begin
        if (w_wr_fire && !w_wr_oor) begin
            r_mem[wr_addr] <= wr_data;
        end
        if (w_rd_fire) begin
            r_s1_data <= w_rd_oor ? '0 : r_mem[addr];
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_fifo[r_wr_ptr] <= r_s1_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_s1_v     <= 1'b0;
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_addr_err <= 1'b0;
        end else begin
            r_s1_v <= w_rd_fire;
            if (w_push) begin
                r_wr_ptr <= f_ptr_next(r_wr_ptr);
            end
            if (w_pop) begin
                r_rd_ptr <= f_ptr_next(r_rd_ptr);
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + CNT_W'(1);
            end else if (!w_push && w_pop) begin
                r_count <= r_count - CNT_W'(1);
            end
            if ((w_wr_fire && w_wr_oor) || (w_rd_fire && w_rd_oor)) begin
                r_addr_err <= 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: doc/img_mem_reader.md
# img_mem_reader

Image memory responder: holds one IMG_WIDTH×IMG_HEIGHT frame of W_DATA pixels and serves the pixel-fetch read protocol. It accepts linear read addresses on a valid/ready address channel and returns the addressed pixels, in request order, on a valid/ready data stream. It sits opposite the window fetch path: its addr channel connects to the fetcher's address output, and its dout stream feeds the fetcher's din input. A separate write stream loads the frame.

## Interface
- W_DATA, 8, pixel width
- IMG_WIDTH, 41, frame width in pixels
- IMG_HEIGHT, 50, frame height in pixels
- FIFO_DEPTH, 2, output buffer entries; values 2 or more give one read per cycle
- W_ADDR, localparam, $clog2(IMG_WIDTH*IMG_HEIGHT)
- MEM_SIZE, localparam, IMG_WIDTH*IMG_HEIGHT

Ports:
- clk  in  1  single clock; all logic on rising edge
- rst  in  1  reset, asynchronous, active-high
- wr_valid  in  1  frame write request
- wr_ready  out  1  write accepted
- wr_addr  in  W_ADDR  linear write address, y*IMG_WIDTH+x
- wr_data  in  W_DATA  pixel to store
- addr_valid  in  1  read request
- addr_ready  out  1  read request accepted
- addr  in  W_ADDR  linear read address
- dout_valid  out  1  pixel available
- dout_ready  in  1  consumer accepts pixel
- dout_data  out  W_DATA  returned pixel
- addr_err  out  1  sticky flag: an out-of-range address was seen

## Operation
- **Storage:** MEM_SIZE×W_DATA memory with one write port and one synchronous read port. Memory contents are not reset.
- **Write channel:**
  - A write transfers when wr_valid & wr_ready are both high.
  - wr_ready is 1 in every cycle outside reset.
  - A write with wr_addr ≥ MEM_SIZE is dropped and sets addr_err.
- **Read channel:**
  - A read transfers when addr_valid & addr_ready are both high.
  - The memory is read on the accepting edge. Data lands in stage register s1 with its valid bit s1_v.
  - On the next edge, s1 is pushed into the output FIFO.
  - dout_data/dout_valid come from the FIFO head.
- **Out-of-range read:** addr ≥ MEM_SIZE still occupies one response slot. That response returns data 0, and addr_err is set on the accepting edge.
- **Ordering:** responses are returned strictly in acceptance order, with exactly one response per accepted address.
- **Credit flow control:**
  - credits = s1_v + fifo_count.
  - pop = dout_valid & dout_ready.
  - addr_ready = (credits − pop) < FIFO_DEPTH. This is a combinational path from dout_ready.
  - Because of the credit rule, a push into the FIFO never meets a full FIFO. Overflow is impossible by construction, and the bench checks it as an assertion.
- **Read-during-write:** if a read and a write to the same address are accepted on the same edge, the read returns the OLD data (read-first).
- **FIFO:**
  - Circular buffer with read/write pointers and a count.
  - Push and pop in the same cycle leave the count unchanged.
  - Pointers wrap at FIFO_DEPTH.
- **addr_err:** cleared only by rst.

## Timing
- **Reset values:** wr_ready=0, addr_ready=0, dout_valid=0, dout_data=0, addr_err=0. Internally s1_v=0, fifo_count=0, pointers=0.
- **First cycle after rst deasserts:** wr_ready=1 and addr_ready=1.
- **Latency:** an address accepted at edge t gives dout_valid=1 in the cycle after edge t+1. That is 2 cycles from the address handshake to data visible, assuming the FIFO was empty.
- **Throughput:** one read per cycle sustained while dout_ready=1, for FIFO_DEPTH ≥ 2.
- **Backpressure with dout_ready=0:** at most FIFO_DEPTH reads are accepted, then addr_ready stays 0. The first cycle dout_ready returns to 1, addr_ready is 1 again in that same cycle.
- **dout stability:** while dout_valid=1 and dout_ready=0, dout_data is held stable.
- **Reset mid-operation:** takes effect immediately, without waiting for a clock edge. In-flight and buffered responses are discarded and are not replayed after reset; already-written memory contents are retained.

## Test plan
- **Load and sequential read:**
  - Stimulus: write mem[i]=i mod 256 for all 2050 addresses, then stream read addresses 0..2049 with dout_ready=1.
  - Required response: dout_data = 0,1,…,1 (2049 mod 256). addr_ready stays 1 throughout, and the first dout_valid appears 2 cycles after the first address handshake.
- **Backpressure:**
  - Stimulus: hold dout_ready=0 and present addresses 5,6,7.
  - Required response: exactly 2 accepted, then addr_ready=0. When dout_ready is raised, outputs are 5,6,7 in order; addr_ready=1 in the same cycle dout_ready rises.
- **Out-of-range:**
  - Stimulus: read 2050, then read 3.
  - Required response: outputs 0 then 3. addr_err=1 from the cycle after the first handshake and stays 1.
- **Read-during-write:**
  - Stimulus: mem[10]=0x11; on the same edge, write 0x22 to address 10 and accept a read of address 10; then read address 10 again.
  - Required response: 0x11, then 0x22.
- **Random stall:**
  - Stimulus: 1000 random-address reads with random addr_valid and dout_ready toggling.
  - Required response: every response matches the reference model in order; FIFO never overflows.
- **Reset mid-stream:**
  - Stimulus: assert rst while 2 responses are buffered.
  - Required response: dout_valid=0 immediately with no clock edge needed, and no stale data after release. A subsequent read of a pre-reset-written address returns the written value.
